// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the on-chip RAM copy master: bus width defaults,
// FSM state encoding and bus constants.
package onchip_mem_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 64;

  // Byte enable pattern for a full-word write at the default data width.
  localparam logic [DATA_W_DEF/8-1:0] BE_ALL = '1;

  // Largest legal word count at the default address width (whole RAM).
  localparam int MAX_WORDS = 2**ADDR_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RWAIT,
    ST_WR,
    ST_FIN
  } copy_state_t;

endpackage

// File: rtl/onchip_mem_copy_master_if.sv
// Avalon-MM bus between the copy master and the single-port on-chip RAM slave.
interface onchip_mem_copy_master_if
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, chipselect, write, byteenable, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, byteenable, writedata,
    output readdata
  );

endinterface

// File: rtl/onchip_mem_copy_master.sv
// Block copy engine for the on-chip RAM: reads a word at the source address,
// writes it to the destination address, repeats for word_count words.
// Optional feature macro: ONCHIP_MEM_COPY_CHECKSUM_EN adds a running XOR
// checksum output of every word written by the current command.
module onchip_mem_copy_master
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0]     checksum,
`endif
  onchip_mem_copy_master_if.master avm
);

  localparam logic [ADDR_W:0]       MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [DATA_W/8-1:0]   BE_FULL = '1;
  localparam int                    WAIT_W  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

  copy_state_t         state;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [ADDR_W:0]     remain_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                abort_q;

  // The read word arrives exactly READ_LATENCY cycles after RD, which is the
  // WR cycle itself; it is forwarded straight from the RAM's output register
  // so each word costs only READ_LATENCY+1 cycles. Gated by write so the bus
  // shows zero data outside WR.
  assign avm.writedata = avm.write ? avm.readdata : '0;

  // Copy sequencer: all bus strobes and status flags are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      remain_q       <= '0;
      wait_q         <= '0;
      abort_q        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      avm.address    <= '0;
      avm.chipselect <= 1'b0;
      avm.write      <= 1'b0;
      avm.byteenable <= '0;
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      done           <= 1'b0;
      error          <= 1'b0;
      avm.chipselect <= 1'b0;
      avm.write      <= 1'b0;
      avm.byteenable <= '0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (word_count == '0) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else if (word_count > MAX_CNT) begin
              state <= ST_FIN;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state          <= ST_RD;
              src_q          <= src_addr;
              dst_q          <= dst_addr;
              remain_q       <= word_count;
              abort_q        <= 1'b0;
              avm.address    <= src_addr;
              avm.chipselect <= 1'b1;
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
              checksum       <= '0;
`endif
            end
          end
        end
        ST_RD: begin
          abort_q <= abort_q | abort;
          if (READ_LATENCY == 1) begin
            state          <= ST_WR;
            avm.address    <= dst_q;
            avm.chipselect <= 1'b1;
            avm.write      <= 1'b1;
            avm.byteenable <= BE_FULL;
          end else begin
            state  <= ST_RWAIT;
            wait_q <= WAIT_W'(READ_LATENCY - 2);
          end
        end
        ST_RWAIT: begin
          abort_q <= abort_q | abort;
          if (wait_q == '0) begin
            state          <= ST_WR;
            avm.address    <= dst_q;
            avm.chipselect <= 1'b1;
            avm.write      <= 1'b1;
            avm.byteenable <= BE_FULL;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        ST_WR: begin
          src_q    <= src_q + ADDR_W'(1);
          dst_q    <= dst_q + ADDR_W'(1);
          remain_q <= remain_q - (ADDR_W+1)'(1);
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
          checksum <= checksum ^ avm.readdata;
`endif
          if ((remain_q == (ADDR_W+1)'(1)) || abort_q || abort) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else begin
            state          <= ST_RD;
            avm.address    <= src_q + ADDR_W'(1);
            avm.chipselect <= 1'b1;
          end
        end
        ST_FIN: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          abort_q <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Bench for onchip_mem_copy_master with a behavioural RAM slave and a
// word-level copy reference model. Checksum checks are active when
// ONCHIP_MEM_COPY_CHECKSUM_EN is defined.
module tb_onchip_mem_copy_master;
  import onchip_mem_pkg::*;

  localparam int AW = 14;
  localparam int DW = 64;
  localparam int NW = 1 << AW;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   word_count;
  logic          abort;
  logic          busy;
  logic          done;
  logic          error;
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  onchip_mem_copy_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  onchip_mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .error      (error),
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .avm        (bus)
  );

  logic [DW-1:0] ram     [0:NW-1];
  logic [DW-1:0] ref_mem [0:NW-1];
  logic [DW-1:0] merged;
  logic [AW:0]   trace_q [$];
  int            total;
  int            bad;
  int            lat;
  int            ndone;
  logic          err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM slave: one access per cycle, read latency 1, byte-enabled writes.
  always @(posedge clk) begin
    if (bus.chipselect && bus.write) begin
      merged = ram[bus.address];
      for (int b = 0; b < DW/8; b++)
        if (bus.byteenable[b]) merged[8*b +: 8] = bus.writedata[8*b +: 8];
      ram[bus.address] <= merged;
    end else if (bus.chipselect) begin
      bus.readdata <= ram[bus.address];
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    ram[a]     <= v;
    ref_mem[a]  = v;
  endtask

  // Reference: ascending word-by-word copy, so overlapping sources see
  // words already rewritten. Returns XOR of the written words.
  function automatic logic [DW-1:0] model_copy(logic [AW-1:0] s, logic [AW-1:0] d, int n);
    logic [DW-1:0] x;
    logic [AW-1:0] rs;
    logic [AW-1:0] rd;
    x = '0;
    for (int i = 0; i < n; i++) begin
      rs = s + AW'(i);
      rd = d + AW'(i);
      ref_mem[rd] = ref_mem[rs];
      x = x ^ ref_mem[rd];
    end
    return x;
  endfunction

  function automatic int mem_diff();
    int c;
    c = 0;
    for (int a = 0; a < NW; a++)
      if (ram[a] !== ref_mem[a]) c++;
    return c;
  endfunction

  // 1 when the recorded bus trace is read src+i / write dst+i alternating.
  function automatic bit trace_ok(logic [AW-1:0] s, logic [AW-1:0] d, int n);
    logic [AW-1:0] ea;
    if (trace_q.size() != 2*n) return 1'b0;
    for (int i = 0; i < n; i++) begin
      ea = s + AW'(i);
      if (trace_q[2*i] !== {1'b0, ea}) return 1'b0;
      ea = d + AW'(i);
      if (trace_q[2*i+1] !== {1'b1, ea}) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Issue one command and watch the bus until 4 cycles past done (bounded).
  task automatic do_cmd(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] n,
                        input int abort_rd, input bit poke);
    int rds;
    trace_q.delete();
    lat = 0; ndone = 0; err = 1'bx; rds = 0;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; word_count = n;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      src_addr = AW'($urandom); dst_addr = AW'($urandom); word_count = (AW+1)'($urandom);
      if (poke && cyc == 2) begin
        start = 1'b1; word_count = 15'd5;
      end
      if (bus.chipselect) trace_q.push_back({bus.write, bus.address});
      if (bus.chipselect && !bus.write) begin
        rds++;
        if (rds == abort_rd) abort = 1'b1;
      end
      if (done) begin
        ndone++;
        if (lat == 0) begin lat = cyc; err = error; end
      end
      if (lat != 0 && cyc >= lat + 4) break;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {busy, done, error}); end
    total++; if ({bus.chipselect, bus.write} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {bus.chipselect, bus.write}); end
    total++; if (bus.address !== '0) begin bad++; $display("FAIL reset_address got=%h want=0", bus.address); end
    total++; if (bus.byteenable !== '0) begin bad++; $display("FAIL reset_be got=%h want=0", bus.byteenable); end
    total++; if (bus.writedata !== '0) begin bad++; $display("FAIL reset_wdata got=%h want=0", bus.writedata); end
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
    total++; if (checksum !== '0) begin bad++; $display("FAIL reset_checksum got=%h want=0", checksum); end
`endif
    abort = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); abort = 1'b0;
    total++; if (busy !== 1'b0 || bus.chipselect !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b cs=%b want 0 0", busy, bus.chipselect); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] ck;
    for (int k = 0; k < 4; k++) preload(AW'(16 + k), {8{8'(k + 1)}});
    do_cmd(14'h010, 14'h100, 15'd4, 0, 1'b0);
    ck = model_copy(14'h010, 14'h100, 4);
    total++; if (lat !== 9) begin bad++; $display("FAIL basic_done_cycle got=%0d want=9", lat); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_error got=%b want=0", err); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", ndone); end
    total++; if (trace_ok(14'h010, 14'h100, 4) !== 1'b1) begin bad++; $display("FAIL basic_trace got_len=%0d want_len=8", trace_q.size()); end
    total++; if (ram[14'h103] !== 64'h0404_0404_0404_0404) begin bad++; $display("FAIL basic_last_word got=%h want=0404040404040404", ram[14'h103]); end
    total++; if (mem_diff() !== 0) begin bad++; $display("FAIL basic_mem got=%0d diffs want=0", mem_diff()); end
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
    total++; if (checksum !== ck) begin bad++; $display("FAIL basic_checksum got=%h want=%h", checksum, ck); end
`endif
  endtask

  task automatic test_zero_and_oversize();
    do_cmd(14'h020, 14'h200, 15'd0, 0, 1'b0);
    total++; if (lat !== 1 || err !== 1'b0) begin bad++; $display("FAIL zero_done got_lat=%0d err=%b want 1 0", lat, err); end
    total++; if (trace_q.size() !== 0) begin bad++; $display("FAIL zero_no_access got=%0d want=0", trace_q.size()); end
    do_cmd(14'h020, 14'h200, 15'd16385, 0, 1'b0);
    total++; if (lat !== 1 || err !== 1'b1) begin bad++; $display("FAIL over_done got_lat=%0d err=%b want 1 1", lat, err); end
    total++; if (trace_q.size() !== 0 || ndone !== 1) begin bad++; $display("FAIL over_no_access got=%0d dones=%0d want 0 1", trace_q.size(), ndone); end
    do_cmd(14'h020, 14'h200, 15'h7FFF, 0, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL max_count_error got=%b want=1", err); end
    total++; if (mem_diff() !== 0) begin bad++; $display("FAIL zero_mem got=%0d diffs want=0", mem_diff()); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] ck;
    logic [DW-1:0] first;
    first = {$urandom, $urandom};
    preload(14'h3FFE, first);
    preload(14'h3FFF, {$urandom, $urandom});
    preload(14'h0000, {$urandom, $urandom});
    preload(14'h0001, {$urandom, $urandom});
    do_cmd(14'h3FFE, 14'h0000, 15'd4, 0, 1'b0);
    ck = model_copy(14'h3FFE, 14'h0000, 4);
    total++; if (trace_ok(14'h3FFE, 14'h0000, 4) !== 1'b1) begin bad++; $display("FAIL wrap_trace got_len=%0d want_len=8", trace_q.size()); end
    total++; if (ram[2] !== first) begin bad++; $display("FAIL wrap_reread got=%h want=%h", ram[2], first); end
    total++; if (mem_diff() !== 0) begin bad++; $display("FAIL wrap_mem got=%0d diffs want=0", mem_diff()); end
    total++; if (lat !== 9) begin bad++; $display("FAIL wrap_done_cycle got=%0d want=9", lat); end
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
    total++; if (checksum !== ck) begin bad++; $display("FAIL wrap_checksum got=%h want=%h", checksum, ck); end
`endif
  endtask

  task automatic test_abort();
    logic [DW-1:0] ck;
    do_cmd(14'h500, 14'h600, 15'd8, 3, 1'b1);
    ck = model_copy(14'h500, 14'h600, 3);
    total++; if (trace_ok(14'h500, 14'h600, 3) !== 1'b1) begin bad++; $display("FAIL abort_trace got_len=%0d want_len=6", trace_q.size()); end
    total++; if (lat !== 7 || err !== 1'b0) begin bad++; $display("FAIL abort_done got_lat=%0d err=%b want 7 0", lat, err); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL abort_single_done got=%0d want=1", ndone); end
    total++; if (mem_diff() !== 0) begin bad++; $display("FAIL abort_mem got=%0d diffs want=0", mem_diff()); end
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
    total++; if (checksum !== ck) begin bad++; $display("FAIL abort_checksum got=%h want=%h", checksum, ck); end
`endif
  endtask

  task automatic test_reset_mid_wr();
    bit hit;
    hit = 1'b0;
    @(negedge clk);
    start = 1'b1; src_addr = 14'h040; dst_addr = 14'h080; word_count = 15'd4;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.chipselect && bus.write) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL midwr_reached got=%b want=1", hit); end
    #2 reset = 1'b1;
    #1;
    total++; if ({busy, done, error, bus.chipselect, bus.write} !== 5'b0) begin bad++; $display("FAIL midwr_async_ctl got=%b want=00000", {busy, done, error, bus.chipselect, bus.write}); end
    total++; if (bus.byteenable !== '0 || bus.writedata !== '0 || bus.address !== '0) begin bad++; $display("FAIL midwr_async_bus be=%h wd=%h a=%h want 0", bus.byteenable, bus.writedata, bus.address); end
    @(negedge clk); reset = 1'b0;
    total++; if (mem_diff() !== 0) begin bad++; $display("FAIL midwr_no_write got=%0d diffs want=0", mem_diff()); end
    do_cmd(14'h040, 14'h080, 15'd4, 0, 1'b0);
    void'(model_copy(14'h040, 14'h080, 4));
    total++; if (lat !== 9 || err !== 1'b0) begin bad++; $display("FAIL midwr_after got_lat=%0d err=%b want 9 0", lat, err); end
    total++; if (mem_diff() !== 0) begin bad++; $display("FAIL midwr_after_mem got=%0d diffs want=0", mem_diff()); end
  endtask

  task automatic test_random();
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    int n;
    logic [DW-1:0] ck;
    for (int it = 0; it < 8; it++) begin
      s = AW'($urandom);
      d = (it % 2 == 0) ? AW'(s + AW'($urandom_range(1, 6))) : AW'($urandom);
      n = $urandom_range(1, 24);
      do_cmd(s, d, (AW+1)'(n), 0, 1'b0);
      ck = model_copy(s, d, n);
      total++; if (lat !== 2*n + 1 || err !== 1'b0) begin bad++; $display("FAIL rand%0d_done got_lat=%0d err=%b want %0d 0", it, lat, err, 2*n + 1); end
      total++; if (trace_ok(s, d, n) !== 1'b1) begin bad++; $display("FAIL rand%0d_trace got_len=%0d want_len=%0d", it, trace_q.size(), 2*n); end
      total++; if (mem_diff() !== 0) begin bad++; $display("FAIL rand%0d_mem got=%0d diffs want=0", it, mem_diff()); end
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
      total++; if (checksum !== ck) begin bad++; $display("FAIL rand%0d_checksum got=%h want=%h", it, checksum, ck); end
`endif
    end
  endtask

`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
  task automatic test_checksum();
    preload(14'h0200, {16{4'hF, 4'h0}});
    preload(14'h0201, {16{4'h0, 4'hF}});
    preload(14'h0202, {DW{1'b1}});
    do_cmd(14'h0200, 14'h0300, 15'd3, 0, 1'b0);
    void'(model_copy(14'h0200, 14'h0300, 3));
    total++; if (checksum !== 64'h0) begin bad++; $display("FAIL cks_cancel got=%h want=0", checksum); end
    preload(14'h0210, 64'h1);
    preload(14'h0211, 64'h2);
    do_cmd(14'h0210, 14'h0310, 15'd2, 0, 1'b0);
    void'(model_copy(14'h0210, 14'h0310, 2));
    total++; if (checksum !== 64'h3) begin bad++; $display("FAIL cks_small got=%h want=3", checksum); end
    do_cmd(14'h0210, 14'h0310, 15'd16385, 0, 1'b0);
    total++; if (checksum !== 64'h3) begin bad++; $display("FAIL cks_hold_on_reject got=%h want=3", checksum); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; word_count = '0;
    for (int a = 0; a < NW; a++) preload(AW'(a), {$urandom, $urandom});
    test_reset();
    test_basic();
    test_zero_and_oversize();
    test_wrap();
    test_abort();
    test_reset_mid_wr();
    test_random();
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
